// File: rtl/ui_pkg.sv
// Shared definitions for the synth UI marker path: event codes, marker
// groups, screen positions of every marker and the sequencer FSM states.
package ui_pkg;

  // Event codes: 0..11 are notes, 16..21 are the six control buttons.
  localparam logic [4:0] EV_NOTE_MAX = 5'd11;
  localparam logic [4:0] EV_OCT_UP   = 5'd16;
  localparam logic [4:0] EV_OCT_DN   = 5'd17;
  localparam logic [4:0] EV_AMP_UP   = 5'd18;
  localparam logic [4:0] EV_AMP_DN   = 5'd19;
  localparam logic [4:0] EV_ADSR_UP  = 5'd20;
  localparam logic [4:0] EV_ADSR_DN  = 5'd21;

  // Event sources, index order is also arbitration priority (0 = highest).
  localparam int NUM_SRC = 7;

  // Marker groups: each group keeps one marker on screen.
  localparam logic GRP_NOTE = 1'b0;
  localparam logic GRP_CTRL = 1'b1;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
  } pos_t;

  // Key marker positions; black keys sit higher on the keyboard drawing.
  localparam pos_t NOTE_POS [12] = '{
    '{9'd66,  8'd124}, '{9'd81,  8'd96},  '{9'd99,  8'd124}, '{9'd112, 8'd96},
    '{9'd131, 8'd124}, '{9'd161, 8'd124}, '{9'd174, 8'd96},  '{9'd192, 8'd124},
    '{9'd209, 8'd96},  '{9'd224, 8'd124}, '{9'd245, 8'd96},  '{9'd254, 8'd124}
  };

  // Control markers all share one row.
  localparam logic [7:0] CTRL_Y    = 8'd169;
  localparam logic [8:0] OCT_UP_X  = 9'd103;
  localparam logic [8:0] OCT_DN_X  = 9'd71;
  localparam logic [8:0] AMP_UP_X  = 9'd215;
  localparam logic [8:0] AMP_DN_X  = 9'd247;
  localparam logic [8:0] ADSR_UP_X = 9'd153;
  localparam logic [8:0] ADSR_DN_X = 9'd183;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE_GO,
    S_ERASE_WAIT,
    S_DRAW_GO,
    S_DRAW_WAIT
  } state_e;

  // Controls have bit 4 set, notes do not.
  function automatic logic code_group(input logic [4:0] code);
    return code[4] ? GRP_CTRL : GRP_NOTE;
  endfunction

endpackage

// File: rtl/marker_pos_rom.sv
// Combinational map from an event code to the marker box origin.
module marker_pos_rom
  import ui_pkg::*;
(
  input  logic [4:0] i_code,
  output pos_t       o_pos
);

  // Table lookup: notes index the key table, controls decode individually.
  always_comb begin
    // NOTE: default first so every path assigns o_pos and no latch is inferred.
    o_pos = '0;
    if (i_code <= EV_NOTE_MAX) begin
      o_pos = NOTE_POS[i_code[3:0]];
    end else begin
      case (i_code)
        EV_OCT_UP:  o_pos = '{x: OCT_UP_X,  y: CTRL_Y};
        EV_OCT_DN:  o_pos = '{x: OCT_DN_X,  y: CTRL_Y};
        EV_AMP_UP:  o_pos = '{x: AMP_UP_X,  y: CTRL_Y};
        EV_AMP_DN:  o_pos = '{x: AMP_DN_X,  y: CTRL_Y};
        EV_ADSR_UP: o_pos = '{x: ADSR_UP_X, y: CTRL_Y};
        EV_ADSR_DN: o_pos = '{x: ADSR_DN_X, y: CTRL_Y};
        default:    o_pos = '0;
      endcase
    end
  end

endmodule

// File: rtl/ui_marker_sequencer.sv
// Turns note/control user events into erase-then-draw box commands for the
// VGA box plotter. Events are edge-detected, coalesced into per-source
// pending flags, queued by priority and replayed one command at a time,
// each command waiting for the plotter's done pulse.
module ui_marker_sequencer
  import ui_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [2:0] MARK_COLOUR = 3'b110,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic [3:0] iNote,
  input  logic       iNoteValid,
  input  logic       iOctUp,
  input  logic       iOctDown,
  input  logic       iAmpUp,
  input  logic       iAmpDown,
  input  logic       iAdsrUp,
  input  logic       iAdsrDown,
  input  logic       iBoxDone,
  output logic [8:0] oBoxX,
  output logic [7:0] oBoxY,
  output logic [2:0] oBoxColour,
  output logic       oBoxStart,
  output logic       oBusy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // ---------------- event detection ----------------
  logic [5:0]         r_prev_btn;
  logic               r_prev_nv;
  logic [3:0]         r_prev_note;
  logic [5:0]         w_btn;
  logic [5:0]         w_btn_rise;
  logic               w_note_ev;
  logic [NUM_SRC-1:0] w_detect;

  // Button order matches source priority after the note source.
  assign w_btn      = {iAdsrDown, iAdsrUp, iAmpDown, iAmpUp, iOctDown, iOctUp};
  assign w_btn_rise = w_btn & ~r_prev_btn;
  assign w_note_ev  = iNoteValid && (!r_prev_nv || (iNote != r_prev_note)) &&
                      ({1'b0, iNote} <= EV_NOTE_MAX);
  assign w_detect   = {w_btn_rise, w_note_ev};

  // Previous-value registers for edge and change detection.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      r_prev_btn  <= '0;
      r_prev_nv   <= 1'b0;
      r_prev_note <= '0;
    end else begin
      r_prev_btn  <= w_btn;
      r_prev_nv   <= iNoteValid;
      r_prev_note <= iNote;
    end
  end

  // ---------------- pending flags and arbiter ----------------
  logic [NUM_SRC-1:0] r_pend;
  logic [3:0]         r_pend_note;
  logic [NUM_SRC-1:0] w_grant;
  logic [4:0]         w_push_code;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;

  // Fixed priority pick: scanning downward leaves the lowest pending index.
  always_comb begin
    w_grant     = '0;
    w_push_code = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_grant     = '0;
        w_grant[i]  = 1'b1;
        w_push_code = (i == 0) ? {1'b0, r_pend_note} : EV_OCT_UP + 5'(i - 1);
      end
    end
  end

  // A slot freed by a same-cycle pop may be refilled immediately.
  assign w_push = (|r_pend) && (!w_full || w_pop);

  // Pending flags: clear on push, a fresh detect wins over the clear.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      r_pend      <= '0;
      r_pend_note <= '0;
    end else begin
      r_pend <= (r_pend & ~(w_push ? w_grant : '0)) | w_detect;
      if (w_note_ev) r_pend_note <= iNote;
    end
  end

  // ---------------- event FIFO ----------------
  logic [4:0]  r_fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [4:0]    w_head;

  assign w_full  = (r_count == (AW + 1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo_mem[r_rd_ptr];

  // Storage write.
  // NOTE: the queue storage has no reset; r_count alone says which entries
  // are valid, so the array can map onto plain RAM/registers without reset.
  always_ff @(posedge iClock) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= w_push_code;
  end

  // Ring pointers and occupancy.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- command sequencer ----------------
  state_e      r_state;
  state_e      w_state_next;
  logic [4:0]  r_cur_code;
  logic [1:0]  r_grp_valid;
  pos_t        r_grp_pos [2];
  logic [4:0]  w_sel_code;
  logic        w_sel_grp;
  pos_t        w_rom_pos;
  logic        w_load;
  pos_t        w_cmd_pos;
  logic [2:0]  w_cmd_colour;
  logic        w_grp_update;
  logic [8:0]  r_box_x;
  logic [7:0]  r_box_y;
  logic [2:0]  r_box_colour;
  logic        r_box_start;

  // In IDLE the event being launched is still at the FIFO head.
  assign w_sel_code = (r_state == S_IDLE) ? w_head : r_cur_code;
  assign w_sel_grp  = code_group(w_sel_code);
  assign w_pop      = (r_state == S_IDLE) && !w_empty;

  marker_pos_rom u_pos_rom (
    .i_code (w_sel_code),
    .o_pos  (w_rom_pos)
  );

  // Next state and the command to load when entering a *_GO state.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_cmd_pos    = w_rom_pos;
    w_cmd_colour = MARK_COLOUR;
    w_grp_update = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_load = 1'b1;
          if (r_grp_valid[w_sel_grp]) begin
            w_state_next = S_ERASE_GO;
            w_cmd_pos    = r_grp_pos[w_sel_grp];
            w_cmd_colour = BG_COLOUR;
          end else begin
            w_state_next = S_DRAW_GO;
          end
        end
      end
      S_ERASE_GO:   w_state_next = S_ERASE_WAIT;
      S_ERASE_WAIT: begin
        if (iBoxDone) begin
          w_state_next = S_DRAW_GO;
          w_load       = 1'b1;
        end
      end
      S_DRAW_GO:    w_state_next = S_DRAW_WAIT;
      S_DRAW_WAIT: begin
        if (iBoxDone) begin
          w_state_next = S_IDLE;
          w_grp_update = 1'b1;
        end
      end
      default:      w_state_next = S_IDLE;
    endcase
  end

  // State, current event and per-group marker memory.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      r_state      <= S_IDLE;
      r_cur_code   <= '0;
      r_grp_valid  <= '0;
      r_grp_pos[0] <= '0;
      r_grp_pos[1] <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) r_cur_code <= w_head;
      if (w_grp_update) begin
        r_grp_pos[w_sel_grp]   <= w_rom_pos;
        r_grp_valid[w_sel_grp] <= 1'b1;
      end
    end
  end

  // Registered command outputs: strobe for one cycle, hold X/Y/colour.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      r_box_x      <= '0;
      r_box_y      <= '0;
      r_box_colour <= '0;
      r_box_start  <= 1'b0;
    end else begin
      r_box_start <= w_load;
      if (w_load) begin
        r_box_x      <= w_cmd_pos.x;
        r_box_y      <= w_cmd_pos.y;
        r_box_colour <= w_cmd_colour;
      end
    end
  end

  assign oBoxX      = r_box_x;
  assign oBoxY      = r_box_y;
  assign oBoxColour = r_box_colour;
  assign oBoxStart  = r_box_start;
  assign oBusy      = (r_state != S_IDLE) || !w_empty || (|r_pend);

endmodule

// File: tb/tb_ui_marker_sequencer.sv
// Bench for ui_marker_sequencer: directed user events, a plotter model that
// answers each strobe with a done pulse (stallable), and an expected-command
// model built from marker groups and the position table.
module tb_ui_marker_sequencer;

  logic       iClock = 1'b0;
  logic       iResetn;
  logic [3:0] iNote;
  logic       iNoteValid;
  logic       iOctUp, iOctDown, iAmpUp, iAmpDown, iAdsrUp, iAdsrDown;
  logic       iBoxDone;
  logic [8:0] oBoxX;
  logic [7:0] oBoxY;
  logic [2:0] oBoxColour;
  logic       oBoxStart;
  logic       oBusy;

  logic plot_done  = 1'b0;
  logic stray_done = 1'b0;
  bit   stall      = 1'b0;
  int   rst_epoch  = 0;

  assign iBoxDone = plot_done | stray_done;

  always #5 iClock = ~iClock;

  ui_marker_sequencer dut (
    .iClock     (iClock),
    .iResetn    (iResetn),
    .iNote      (iNote),
    .iNoteValid (iNoteValid),
    .iOctUp     (iOctUp),
    .iOctDown   (iOctDown),
    .iAmpUp     (iAmpUp),
    .iAmpDown   (iAmpDown),
    .iAdsrUp    (iAdsrUp),
    .iAdsrDown  (iAdsrDown),
    .iBoxDone   (iBoxDone),
    .oBoxX      (oBoxX),
    .oBoxY      (oBoxY),
    .oBoxColour (oBoxColour),
    .oBoxStart  (oBoxStart),
    .oBusy      (oBusy)
  );

  // ---------------- scoring ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- expected-command model ----------------
  typedef struct {
    int x;
    int y;
    int c;
  } cmd_t;

  cmd_t exp_q[$];
  int   note_x [12] = '{66, 81, 99, 112, 131, 161, 174, 192, 209, 224, 245, 254};
  int   note_y [12] = '{124, 96, 124, 96, 124, 124, 96, 124, 96, 124, 96, 124};
  bit   grp_valid [2];
  int   grp_x [2];
  int   grp_y [2];

  function automatic void model_reset();
    for (int g = 0; g < 2; g++) begin
      grp_valid[g] = 1'b0;
      grp_x[g]     = 0;
      grp_y[g]     = 0;
    end
  endfunction

  // One user event: erase the group's old marker if any, then draw the new.
  function automatic void expect_event(input int code);
    int   g;
    int   x;
    int   y;
    cmd_t e;
    g = (code >= 16) ? 1 : 0;
    if (code < 12) begin
      x = note_x[code];
      y = note_y[code];
    end else begin
      y = 169;
      case (code)
        16:      x = 103;
        17:      x = 71;
        18:      x = 215;
        19:      x = 247;
        20:      x = 153;
        default: x = 183;
      endcase
    end
    if (grp_valid[g]) begin
      e = '{x: grp_x[g], y: grp_y[g], c: 0};
      exp_q.push_back(e);
    end
    e = '{x: x, y: y, c: 6};
    exp_q.push_back(e);
    grp_valid[g] = 1'b1;
    grp_x[g]     = x;
    grp_y[g]     = y;
  endfunction

  // ---------------- compare process ----------------
  int n_starts = 0;

  initial begin : compare
    int   hold_x;
    int   hold_y;
    int   hold_c;
    bit   prev_start;
    cmd_t e;
    hold_x = 0; hold_y = 0; hold_c = 0; prev_start = 1'b0;
    forever begin
      @(negedge iClock);
      if (!iResetn) begin
        hold_x = 0; hold_y = 0; hold_c = 0;
      end
      if (oBoxStart) begin
        n_starts++;
        check("start_width", int'(prev_start), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_start", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("cmd_x", oBoxX, e.x);
          check("cmd_y", oBoxY, e.y);
          check("cmd_colour", oBoxColour, e.c);
          hold_x = e.x; hold_y = e.y; hold_c = e.c;
        end
      end else begin
        check("hold_x", oBoxX, hold_x);
        check("hold_y", oBoxY, hold_y);
        check("hold_colour", oBoxColour, hold_c);
      end
      prev_start = oBoxStart;
    end
  end

  // ---------------- plotter model ----------------
  initial begin : plotter
    int ep;
    @(negedge iClock);
    forever begin
      if (oBoxStart && iResetn) begin
        ep = rst_epoch;
        @(negedge iClock);
        while (stall && ep == rst_epoch) @(negedge iClock);
        if (ep == rst_epoch) begin
          plot_done = 1'b1;
          @(negedge iClock);
          plot_done = 1'b0;
        end
      end else begin
        @(negedge iClock);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge iClock);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((oBusy || exp_q.size() != 0) && n < budget) begin
      @(negedge iClock);
      n++;
    end
    check({name, "_timeout"}, int'(n >= budget), 0);
    check({name, "_busy"}, oBusy, 0);
    check({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int  lat;
    bit  seen;
    int  s0;
    int  n;

    iResetn = 1'b0; iNote = '0; iNoteValid = 1'b0;
    iOctUp = 0; iOctDown = 0; iAmpUp = 0; iAmpDown = 0; iAdsrUp = 0; iAdsrDown = 0;
    model_reset();
    step(3);
    check("rst_x", oBoxX, 0);
    check("rst_y", oBoxY, 0);
    check("rst_colour", oBoxColour, 0);
    check("rst_start", oBoxStart, 0);
    check("rst_busy", oBusy, 0);
    iResetn = 1'b1;
    step(2);

    // First note: draw only, three clocks after the sampling edge.
    iNote = 4'd2; iNoteValid = 1'b1;
    expect_event(2);
    s0 = n_starts; lat = 0; seen = 1'b0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge iClock);
      if (oBoxStart) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check("t1_latency", lat, 3);
    check("t1_x", oBoxX, 99);
    check("t1_y", oBoxY, 124);
    check("t1_colour", oBoxColour, 6);
    wait_idle("t1", 60);
    check("t1_starts", n_starts - s0, 1);

    // Note change: erase old, draw new.
    s0 = n_starts;
    iNote = 4'd4;
    expect_event(4);
    wait_idle("t2", 80);
    check("t2_starts", n_starts - s0, 2);
    check("t2_x", oBoxX, 131);
    check("t2_colour", oBoxColour, 6);

    // Two controls in one cycle: priority order octUp then ampDown.
    s0 = n_starts;
    iOctUp = 1'b1; iAmpDown = 1'b1;
    expect_event(16);
    expect_event(19);
    step(2);
    iOctUp = 1'b0; iAmpDown = 1'b0;
    wait_idle("t3", 120);
    check("t3_starts", n_starts - s0, 3);
    check("t3_x", oBoxX, 247);
    check("t3_y", oBoxY, 169);

    // Stalled plotter: fill the queue, then coalesce on pending flags.
    stall = 1'b1;
    iNote = 4'd6;  expect_event(6);  step(4);
    iAdsrUp = 1'b1;   expect_event(20); step(3);
    iAdsrDown = 1'b1; expect_event(21); step(3);
    iOctDown = 1'b1;  expect_event(17); step(3);
    iAmpUp = 1'b1;    expect_event(18); step(3);
    check("t4_busy_full", oBusy, 1);
    for (int k = 0; k < 3; k++) begin
      iOctUp = 1'b1; step(2);
      iOctUp = 1'b0; step(2);
    end
    for (int k = 7; k <= 11; k++) begin
      iNote = 4'(k); step(2);
    end
    iAmpDown = 1'b1; step(2);
    expect_event(11);
    expect_event(16);
    expect_event(19);
    check("t4_busy_pend", oBusy, 1);
    check("t4_stalled_queue", exp_q.size(), 15);
    iAdsrUp = 0; iAdsrDown = 0; iOctDown = 0; iAmpUp = 0; iAmpDown = 0;
    stall = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge iClock);
      check("t4_busy_drain", oBusy, 1);
      n++;
    end
    check("t4_drain_timeout", int'(n >= 600), 0);
    wait_idle("t4", 60);
    check("t4_last_x", oBoxX, 247);

    // Reset while waiting for the erase to finish.
    stall = 1'b1;
    iNote = 4'd3;
    expect_event(3);
    step(5);
    check("t6_erase_issued", exp_q.size(), 1);
    check("t6_erase_x_held", oBoxX, 254);
    #2;
    iResetn = 1'b0;
    rst_epoch++;
    #1;
    check("t6_rst_x", oBoxX, 0);
    check("t6_rst_y", oBoxY, 0);
    check("t6_rst_colour", oBoxColour, 0);
    check("t6_rst_start", oBoxStart, 0);
    check("t6_rst_busy", oBusy, 0);
    exp_q.delete();
    model_reset();
    stall = 1'b0;
    step(2);
    iResetn = 1'b1;
    s0 = n_starts;
    expect_event(3);
    wait_idle("t6", 80);
    check("t6_starts", n_starts - s0, 1);
    check("t6_x", oBoxX, 112);
    check("t6_y", oBoxY, 96);

    // Out-of-range note and a stray done pulse are both ignored.
    s0 = n_starts;
    iNote = 4'd13;
    for (int k = 0; k < 6; k++) begin
      step(1);
      check("t7_busy", oBusy, 0);
    end
    stray_done = 1'b1; step(1); stray_done = 1'b0;
    step(4);
    check("t7_busy_stray", oBusy, 0);
    check("t7_starts", n_starts - s0, 0);

    // Same note again: erase and redraw at the same spot.
    s0 = n_starts;
    iNote = 4'd3;
    expect_event(3);
    wait_idle("t8", 80);
    check("t8_starts", n_starts - s0, 2);

    // Control group was cleared by reset: draw with no erase.
    s0 = n_starts;
    iOctUp = 1'b1;
    expect_event(16);
    wait_idle("t9", 80);
    iOctUp = 1'b0;
    check("t9_starts", n_starts - s0, 1);
    check("t9_x", oBoxX, 103);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ui_marker_sequencer.md
Name: ui_marker_sequencer

Overview:
- Upstream stage of the VGA box plotter in the synth UI path.
- Converts note, octave, amplitude and ADSR user events into an ordered stream of box-draw commands (x, y, colour, start).
- For each event, erases the previous marker of the same group, then draws the new one, and waits for the plotter's done pulse between commands.
- Owns event capture, coalescing, queuing and the erase/draw handshake. The plotter owns pixel iteration.

Parameters:
FIFO_DEPTH, 4, event queue depth (power of 2, ≥2)
MARK_COLOUR, 3'b110, colour for drawing a marker
BG_COLOUR, 3'b000, colour for erasing a marker

Ports:
iClock  in  1  system clock
iResetn  in  1  reset; asynchronous, active-low
iNote  in  4  current note index 0–11
iNoteValid  in  1  iNote meaningful
iOctUp / iOctDown / iAmpUp / iAmpDown / iAdsrUp / iAdsrDown  in  1 each  control buttons (level)
iBoxDone  in  1  1-cycle pulse from plotter: box finished
oBoxX  out  9  box origin x
oBoxY  out  8  box origin y
oBoxColour  out  3  box colour
oBoxStart  out  1  1-cycle command strobe to plotter
oBusy  out  1  FSM not IDLE, or FIFO not empty, or any pending flag set

Behaviour:
- Input assumptions: all inputs are synchronous to iClock and debounced upstream.
- Reset (async, iResetn=0): all outputs 0, FSM=IDLE, FIFO empty, pending flags clear, both group-valid flags clear, edge-detect registers 0.
- Event detection, one registered previous-value per input:
  - Button event: rising edge of its input.
  - Note event: iNoteValid rising, or iNote change while iNoteValid=1, with iNote ≤ 11.
  - Notes 12–15 never generate an event.
- Event codes (5 bit): 0–11 note; 16 octUp; 17 octDown; 18 ampUp; 19 ampDown; 20 adsrUp; 21 adsrDown.
- Pending flags, one per source:
  - Set on detect.
  - A repeat detect while already pending coalesces into the same flag.
  - The note pending entry holds the latest note value.
- Arbiter, each cycle while the FIFO is not full:
  - Pushes one pending event by fixed priority: note > octUp > octDown > ampUp > ampDown > adsrUp > adsrDown.
  - Clears that flag in the same cycle.
  - A detect on the same source in the same cycle re-sets the flag.
  - FIFO full: flags hold. Nothing is ever dropped.
- Marker groups:
  - Note group: codes 0–11.
  - Control group: codes 16–21.
  - Each group keeps a last-position register and a valid flag.
- Position table (combinational), as (x, y):
  - Notes 0–11: (66,124) (81,96) (99,124) (112,96) (131,124) (161,124) (174,96) (192,124) (209,96) (224,124) (245,96) (254,124).
  - Controls: octUp (103,169), octDown (71,169), ampUp (215,169), ampDown (247,169), adsrUp (153,169), adsrDown (183,169).
- FSM states: IDLE, ERASE_GO, ERASE_WAIT, DRAW_GO, DRAW_WAIT.
  - IDLE: if FIFO not empty, pop into the current-event register. Go to ERASE_GO if the group valid flag is set, else DRAW_GO.
  - ERASE_GO: oBoxStart=1 for one cycle; X/Y = group last position; colour = BG_COLOUR. Go to ERASE_WAIT.
  - ERASE_WAIT: on iBoxDone go to DRAW_GO.
  - DRAW_GO: oBoxStart=1 for one cycle; X/Y = table position; colour = MARK_COLOUR. Go to DRAW_WAIT.
  - DRAW_WAIT: on iBoxDone, update group last position, set group valid, return to IDLE.
- Handshake rules:
  - oBoxX/Y/Colour are registered, change only in *_GO, and stay stable until the next *_GO.
  - iBoxDone outside a *_WAIT state is ignored.
  - No wait timeout.
- Latency: button rising edge sampled at clock k → pending at k → FIFO push at k+1 → pop at k+2 → oBoxStart high in the cycle after edge k+2 (3 clocks, empty FIFO, IDLE).
- Same position redraw: a note repeated to the same position still performs erase then draw.
- Simultaneous FIFO push and pop: both are allowed, including when the FIFO is full.
- Reset mid-command: returns immediately to the reset state. The plotter is reset by the same iResetn.

Decomposition:
- Shared package ui_pkg:
  - Event-code localparams (EV_NOTE_MAX, EV_OCT_UP … EV_ADSR_DN).
  - Group encoding.
  - Position constants.
- Sub-module marker_pos_rom: pure combinational map from 5-bit code to {x[8:0], y[7:0]}.
- FIFO stays inline: small counter-based ring buffer.

Test Plan:
- Reset, then iNoteValid 0→1 with iNote=2 → 3 clocks later oBoxStart pulse, (99,124), colour 110, no erase. After iBoxDone → IDLE, oBusy=0.
- Note changes 2→4 → erase (99,124) colour 000, iBoxDone, then draw (131,124) colour 110. Exactly two oBoxStart pulses.
- octUp and ampDown rise in the same cycle while idle → draw (103,169); then erase (103,169) and draw (247,169). Order follows priority.
- Hold iBoxDone low, pulse iOctUp 3 times and change the note 5 times → octUp coalesces, only the last note is pushed, no loss. Queue drains in order once done pulses resume.
- Fill the FIFO (plotter stalled, 7 distinct sources) → pending flags retained. All 7 commands eventually issued, oBusy high throughout.
- Assert iResetn=0 during ERASE_WAIT → all outputs 0 asynchronously. After release the next note draws with no erase.
- iNote=13 with iNoteValid=1 → no oBoxStart, oBusy stays 0.
